// File: rtl/fp_sqrt_pipe.sv
// Iterative restoring fixed-point square root, STEPS_PER_CYCLE result bits per clock, go/done handshake.
// Optional macro SQRT_ZERO_SKIP_EN: a zero radicand completes in one cycle without entering RUN.
module fp_sqrt_pipe #(
    parameter int WIDTH           = 32,
    parameter int INT_WIDTH       = 16,
    parameter int FRAC_WIDTH      = 16,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH:0]   rem,
    output logic             done,
    output logic             busy
);

    localparam int ITERATIONS = (WIDTH + FRAC_WIDTH) / 2;
    localparam int STEP_DIV   = (STEPS_PER_CYCLE < 1) ? 1 : STEPS_PER_CYCLE;
    localparam int CYCLES     = (ITERATIONS / STEP_DIV < 1) ? 1 : ITERATIONS / STEP_DIV;
    localparam int XW         = WIDTH + FRAC_WIDTH;
    localparam int AW         = WIDTH + 2;
    localparam int CW         = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    generate
        if ((WIDTH < 1) || (FRAC_WIDTH < 0) || (FRAC_WIDTH > WIDTH) ||
            (((WIDTH + FRAC_WIDTH) % 2) != 0) || (INT_WIDTH + FRAC_WIDTH != WIDTH) ||
            (STEPS_PER_CYCLE < 1) || ((ITERATIONS % STEP_DIV) != 0)) begin : g_bad_params
            $error("fp_sqrt_pipe: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2
    } state_t;

    state_t                  state, next_state;
    logic [XW-1:0]           x, x_c;
    logic [AW-1:0]           acc, acc_c;
    logic [ITERATIONS-1:0]   q, q_c;
    logic [CW-1:0]           counter;
    logic                    start, finish;

    // Restoring steps chained combinationally; each consumes the top two radicand bits.
    always_comb begin
        logic [AW+1:0] sh;
        logic [AW+1:0] trial;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        acc_c = acc;
        x_c   = x;
        q_c   = q;
        sh    = '0;
        trial = '0;
        // NOTE: blocking assignments here so each step sees the previous step's result in the same cycle.
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            sh    = {acc_c, x_c[XW-1 -: 2]};
            trial = {{(AW - ITERATIONS){1'b0}}, q_c, 2'b01};
            if (sh >= trial) begin
                acc_c = AW'(sh - trial);
                q_c   = (q_c << 1) | ITERATIONS'(1);
            end else begin
                acc_c = AW'(sh);
                q_c   = q_c << 1;
            end
            x_c = x_c << 2;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
`ifdef SQRT_ZERO_SKIP_EN
                    if (in == '0) begin
                        next_state = SKIP;
                    end else begin
                        start      = 1'b1;
                        next_state = RUN;
                    end
`else
                    start      = 1'b1;
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (counter == CW'(CYCLES - 1)) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            SKIP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all datapath state is plain flops (no memories), so every register is cleared by reset.
        if (reset) begin
            x       <= '0;
            acc     <= '0;
            q       <= '0;
            counter <= '0;
            out     <= '0;
            rem     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                x       <= XW'(in) << FRAC_WIDTH;
                acc     <= '0;
                q       <= '0;
                counter <= '0;
            end else if (state == RUN) begin
                x       <= x_c;
                acc     <= acc_c;
                q       <= q_c;
                counter <= counter + CW'(1);
            end
            if (finish) begin
                out  <= WIDTH'(q_c);
                rem  <= acc_c[WIDTH:0];
                done <= 1'b1;
            end
            if (state == SKIP) begin
                out  <= '0;
                rem  <= '0;
                done <= 1'b1;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
